// File: rtl/tl_instruction_decode.sv
// MIPS instruction-decode stage: register file, control decode, branch/jump
// resolution in ID, load-use / branch-operand hazard stall and the ID/EX register.
module tl_instruction_decode #(
    parameter int LEN    = 32,
    parameter int NB_REG = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [LEN-1:0]    i_instruccion,
    input  logic [LEN-1:0]    i_adder,
    input  logic              i_wb_reg_write,
    input  logic [NB_REG-1:0] i_wb_rd,
    input  logic [LEN-1:0]    i_wb_data,
    input  logic              i_exmem_reg_write,
    input  logic              i_exmem_mem_read,
    input  logic [NB_REG-1:0] i_exmem_rd,
    input  logic [LEN-1:0]    i_exmem_alu_result,
    output logic [LEN-1:0]    o_branch_dir,
    output logic              o_PCSrc,
    output logic              o_flag_jump,
    output logic [LEN-1:0]    o_dir_jump,
    output logic              o_flag_stall,
    output logic [LEN-1:0]    o_adder,
    output logic [LEN-1:0]    o_rs_data,
    output logic [LEN-1:0]    o_rt_data,
    output logic [LEN-1:0]    o_imm,
    output logic [NB_REG-1:0] o_rs,
    output logic [NB_REG-1:0] o_rt,
    output logic [NB_REG-1:0] o_rd,
    output logic [5:0]        o_opcode,
    output logic [5:0]        o_funct,
    output logic              o_reg_write,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_mem_to_reg,
    output logic              o_alu_src,
    output logic              o_halt
);
    localparam int NREG = 1 << NB_REG;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [LEN-1:0]    regs_q [NREG];
    logic              halted_q;

    logic [LEN-1:0]    adder_q, adder_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [NB_REG-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [5:0]        opcode_q, opcode_d, funct_q, funct_d;
    logic              reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d, alu_src_q, alu_src_d, halt_q, halt_d;

    logic [5:0]        opcode, funct;
    logic [NB_REG-1:0] rs_a, rt_a, rd_a;
    logic [LEN-1:0]    imm_ext, rs_rf, rt_rf, rs_br, rt_br;
    logic              is_rtype, is_jr, is_beq, is_bne, is_j, is_jal, is_halt;
    logic              rt_used, br_rs, br_rt, fwd_rs, fwd_rt, br_eq;
    logic              hz_load_use, hz_idex, hz_exmem, stall;
    logic              dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg, dec_alu_src, dec_halt;
    logic [NB_REG-1:0] dec_rd;

    assign opcode   = i_instruccion[31:26];
    assign funct    = i_instruccion[5:0];
    assign rs_a     = i_instruccion[21 +: NB_REG];
    assign rt_a     = i_instruccion[16 +: NB_REG];
    assign rd_a     = i_instruccion[11 +: NB_REG];
    assign imm_ext  = {{(LEN-16){i_instruccion[15]}}, i_instruccion[15:0]};

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_bne   = (opcode == OP_BNE);
    assign is_j     = (opcode == OP_J);
    assign is_jal   = (opcode == OP_JAL);
    assign is_halt  = (opcode == OP_HALT);
    assign rt_used  = is_rtype || is_beq || is_bne || (opcode == OP_SW);
    assign br_rs    = is_beq || is_bne || is_jr;
    assign br_rt    = is_beq || is_bne;

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_src    = 1'b0;
        dec_halt       = 1'b0;
        dec_rd         = '0;
        case (opcode)
            OP_RTYPE: begin
                dec_reg_write = !is_jr;
                dec_rd        = rd_a;
            end
            OP_ADDI: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_rd        = rt_a;
            end
            OP_LW: begin
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_src    = 1'b1;
                dec_reg_write  = 1'b1;
                dec_rd         = rt_a;
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OP_JAL: begin
                dec_reg_write = 1'b1;
                dec_rd        = NB_REG'(31);
            end
            OP_HALT: dec_halt = 1'b1;
            default: ;
        endcase
    end

    // A write-back to the register being read this cycle is bypassed straight through.
    always_comb begin
        rs_rf = regs_q[rs_a];
        if (rs_a == '0)
            rs_rf = '0;
        else if (i_wb_reg_write && (i_wb_rd == rs_a))
            rs_rf = i_wb_data;
    end

    always_comb begin
        rt_rf = regs_q[rt_a];
        if (rt_a == '0)
            rt_rf = '0;
        else if (i_wb_reg_write && (i_wb_rd == rt_a))
            rt_rf = i_wb_data;
    end

    assign fwd_rs = i_exmem_reg_write && !i_exmem_mem_read && (i_exmem_rd == rs_a) && (rs_a != '0);
    assign fwd_rt = i_exmem_reg_write && !i_exmem_mem_read && (i_exmem_rd == rt_a) && (rt_a != '0);
    assign rs_br  = fwd_rs ? i_exmem_alu_result : rs_rf;
    assign rt_br  = fwd_rt ? i_exmem_alu_result : rt_rf;
    assign br_eq  = (rs_br == rt_br);

    assign hz_load_use = mem_read_q && (rd_q != '0) &&
                         ((rd_q == rs_a) || (rt_used && (rd_q == rt_a)));
    assign hz_idex     = reg_write_q && (rd_q != '0) &&
                         ((br_rs && (rd_q == rs_a)) || (br_rt && (rd_q == rt_a)));
    assign hz_exmem    = i_exmem_mem_read && (i_exmem_rd != '0) &&
                         ((br_rs && (i_exmem_rd == rs_a)) || (br_rt && (i_exmem_rd == rt_a)));
    assign stall       = hz_load_use || hz_idex || hz_exmem || halted_q;

    assign o_flag_stall = !i_rst && stall;
    assign o_PCSrc      = !i_rst && !stall && ((is_beq && br_eq) || (is_bne && !br_eq));
    assign o_flag_jump  = !i_rst && !stall && (is_j || is_jal || is_jr);
    assign o_branch_dir = i_rst ? '0 : i_adder + imm_ext;
    assign o_dir_jump   = i_rst ? '0 : (is_jr ? rs_br : {i_adder[LEN-1:26], i_instruccion[25:0]});

    always_comb begin
        adder_d      = '0;
        rs_data_d    = '0;
        rt_data_d    = '0;
        imm_d        = '0;
        rs_d         = '0;
        rt_d         = '0;
        rd_d         = '0;
        opcode_d     = '0;
        funct_d      = '0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_d    = 1'b0;
        halt_d       = 1'b0;
        if (!stall) begin
            adder_d      = i_adder;
            rs_data_d    = rs_rf;
            rt_data_d    = rt_rf;
            imm_d        = imm_ext;
            rs_d         = rs_a;
            rt_d         = rt_a;
            rd_d         = dec_rd;
            opcode_d     = opcode;
            funct_d      = funct;
            reg_write_d  = dec_reg_write;
            mem_read_d   = dec_mem_read;
            mem_write_d  = dec_mem_write;
            mem_to_reg_d = dec_mem_to_reg;
            alu_src_d    = dec_alu_src;
            halt_d       = dec_halt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
        end else if (i_wb_reg_write && (i_wb_rd != '0)) begin
            regs_q[i_wb_rd] <= i_wb_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            halted_q <= 1'b0;
        else if (!stall && is_halt)
            halted_q <= 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            adder_q      <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            opcode_q     <= '0;
            funct_q      <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_q    <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            adder_q      <= adder_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            opcode_q     <= opcode_d;
            funct_q      <= funct_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_src_q    <= alu_src_d;
            halt_q       <= halt_d;
        end
    end

    assign o_adder      = adder_q;
    assign o_rs_data    = rs_data_q;
    assign o_rt_data    = rt_data_q;
    assign o_imm        = imm_q;
    assign o_rs         = rs_q;
    assign o_rt         = rt_q;
    assign o_rd         = rd_q;
    assign o_opcode     = opcode_q;
    assign o_funct      = funct_q;
    assign o_reg_write  = reg_write_q;
    assign o_mem_read   = mem_read_q;
    assign o_mem_write  = mem_write_q;
    assign o_mem_to_reg = mem_to_reg_q;
    assign o_alu_src    = alu_src_q;
    assign o_halt       = halt_q;
endmodule
